audio_recorder: RTL and testbench

Captures stereo samples from the audio_codec read interface and stores them in a single-port sample RAM as mono 24-bit words. It is the record-side counterpart of the RAM-to-codec playback path. It sits between audio_codec (read_ready/read/readdata_*) and a `ram` instance (address/data/wren). The playback path can later replay the captured buffer. It supports one-shot capture of DEPTH samples or continuous ring capture, and reports the write count and peak level.

---
 rtl/audio_pkg.sv | 15 +
 rtl/audio_mix.sv | 33 +++
 rtl/audio_recorder.sv | 152 +++++++++++++++
 tb/tb_audio_recorder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and default sizes for the audio record path.
// The recorder top and the mix helper both import this package.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    DONE = 2'd2
  } rec_state_t;

  localparam int AUDIO_DATA_W = 24;
  localparam int AUDIO_ADDR_W = 16;
  localparam int AUDIO_DEPTH  = 48000;

endpackage

// File: rtl/audio_mix.sv
// Stereo-to-mono average (floor of (L+R)/2) and saturating magnitude.
// Purely combinational, so the playback-side level meter can reuse it.
module audio_mix
  import audio_pkg::*;
#(
  parameter int DATA_W = AUDIO_DATA_W
) (
  input  logic [DATA_W-1:0] left,
  input  logic [DATA_W-1:0] right,
  output logic [DATA_W-1:0] mono,
  output logic [DATA_W-2:0] mono_abs
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] neg;
  logic              is_min;

  // One guard bit keeps the sum exact; dropping bit 0 is an arithmetic shift.
  assign sum    = {left[DATA_W-1], left} + {right[DATA_W-1], right};
  assign mono   = sum[DATA_W:1];
  assign neg    = -mono;
  assign is_min = mono[DATA_W-1] & ~(|mono[DATA_W-2:0]);

  always_comb begin
    mono_abs = mono[DATA_W-2:0];
    if (is_min) begin
      mono_abs = '1;
    end else if (mono[DATA_W-1]) begin
      mono_abs = neg[DATA_W-2:0];
    end
  end

endmodule

// File: rtl/audio_recorder.sv
// Captures codec samples as mono words into a sample RAM, one-shot or ring,
// tracking the number of samples written and the peak magnitude.
module audio_recorder
  import audio_pkg::*;
#(
  parameter int DATA_W = AUDIO_DATA_W,
  parameter int ADDR_W = AUDIO_ADDR_W,
  parameter int DEPTH  = AUDIO_DEPTH
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done,
  output logic              wrapped,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-2:0] peak
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

  rec_state_t        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              loop_q, loop_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wrapped_q, wrapped_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-2:0] peak_q, peak_d;
  logic              last_capture;

  logic [DATA_W-1:0] mono;
  logic [DATA_W-2:0] mono_abs;

  audio_mix #(.DATA_W(DATA_W)) u_mix (
    .left     (readdata_left),
    .right    (readdata_right),
    .mono     (mono),
    .mono_abs (mono_abs)
  );

  assign read = (state_q == REC) & read_ready & ~stop;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    loop_d       = loop_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_wren_d   = 1'b0;
    wrapped_d    = wrapped_q;
    count_d      = count_q;
    peak_d       = peak_q;
    last_capture = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = REC;
          wr_ptr_d  = '0;
          count_d   = '0;
          peak_d    = '0;
          wrapped_d = 1'b0;
          loop_d    = loop;
        end
      end
      REC: begin
        if (stop) begin
          state_d = DONE;
        end else if (read_ready) begin
          ram_addr_d = wr_ptr_q;
          ram_data_d = mono;
          ram_wren_d = 1'b1;
          if (count_q != FULL_CNT) begin
            count_d = count_q + 1'b1;
          end
          if (mono_abs > peak_q) begin
            peak_d = mono_abs;
          end
          if (wr_ptr_q == LAST_ADDR) begin
            wr_ptr_d = '0;
            if (loop_q) begin
              wrapped_d = 1'b1;
            end else begin
              state_d      = DONE;
              last_capture = 1'b1;
            end
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The state leaves REC with the final capture so read cannot fire again,
    // but busy/done flip only once that final write pulse has been presented.
    busy_d = (state_d == REC) | last_capture;
    done_d = (state_d == DONE) & ~last_capture;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      loop_q     <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrapped_q  <= 1'b0;
      count_q    <= '0;
      peak_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      loop_q     <= loop_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_wren_q <= ram_wren_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wrapped_q  <= wrapped_d;
      count_q    <= count_d;
      peak_q     <= peak_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_wren = ram_wren_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wrapped  = wrapped_q;
  assign count    = count_q;
  assign peak     = peak_q;

endmodule

// File: tb/tb_audio_recorder.sv
// Self-checking bench for audio_recorder with a small buffer (DEPTH=8):
// reference model plus write scoreboard, mix vector table, corner sequences.
module tb_audio_recorder;

  localparam int DW    = 24;
  localparam int AW    = 4;
  localparam int DEPTH = 8;

  localparam int S_IDLE = 0;
  localparam int S_REC  = 1;
  localparam int S_DONE = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, loop = 1'b0, read_ready = 1'b0;
  logic [DW-1:0] l_in = '0, r_in = '0;
  logic          read, ram_wren, busy, done, wrapped;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [AW:0]   count;
  logic [DW-2:0] peak;

  audio_recorder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .CLOCK_50       (clk),
    .reset_n        (reset_n),
    .start          (start),
    .stop           (stop),
    .loop           (loop),
    .read_ready     (read_ready),
    .readdata_left  (l_in),
    .readdata_right (r_in),
    .read           (read),
    .ram_addr       (ram_addr),
    .ram_data       (ram_data),
    .ram_wren       (ram_wren),
    .busy           (busy),
    .done           (done),
    .wrapped        (wrapped),
    .count          (count),
    .peak           (peak)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t sb_q[$];

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [DW-1:0] exp_data;
    logic [DW-2:0] exp_abs;
  } mix_vec_t;
  mix_vec_t vecs[7];

  // reference model state
  int            m_state;
  int            m_ptr;
  int            m_count;
  logic          m_loop;
  logic          m_wrapped;
  logic [DW-2:0] m_peak;
  logic          exp_busy, exp_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mdl_mono(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int s;
    s = int'($signed(l)) + int'($signed(r));
    if (s < 0 && (s % 2) != 0) s = s - 1;
    return DW'(s / 2);
  endfunction

  function automatic logic [DW-2:0] mdl_abs(input logic [DW-1:0] m);
    int v;
    v = int'($signed(m));
    if (v < 0) v = -v;
    if (v > 8388607) v = 8388607;
    return (DW-1)'(v);
  endfunction

  task automatic model_reset();
    m_state   = S_IDLE;
    m_ptr     = 0;
    m_count   = 0;
    m_loop    = 1'b0;
    m_wrapped = 1'b0;
    m_peak    = '0;
    exp_busy  = 1'b0;
    exp_done  = 1'b0;
    sb_q.delete();
  endtask

  // One clock: drive at negedge, check read, advance model, check outputs after posedge.
  task automatic step(input logic st, input logic sp, input logic lp, input logic rr,
                      input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic   cap, last, exp_read;
    logic [DW-1:0] mono;
    wr_t    w;
    @(negedge clk);
    start = st; stop = sp; loop = lp; read_ready = rr; l_in = l; r_in = r;
    #1;
    exp_read = (m_state == S_REC) && rr && !sp;
    check("read", 64'(read), 64'(exp_read));
    cap = 1'b0;
    last = 1'b0;
    if (m_state != S_REC) begin
      if (st) begin
        m_state = S_REC; m_ptr = 0; m_count = 0; m_peak = '0; m_wrapped = 1'b0; m_loop = lp;
      end
    end else if (sp) begin
      m_state = S_DONE;
    end else if (rr) begin
      cap  = 1'b1;
      mono = mdl_mono(l, r);
      w.addr = AW'(m_ptr);
      w.data = mono;
      sb_q.push_back(w);
      if (m_count < DEPTH) m_count++;
      if (mdl_abs(mono) > m_peak) m_peak = mdl_abs(mono);
      if (m_ptr == DEPTH - 1) begin
        m_ptr = 0;
        if (m_loop) m_wrapped = 1'b1;
        else begin
          m_state = S_DONE;
          last = 1'b1;
        end
      end else begin
        m_ptr++;
      end
    end
    exp_busy = (m_state == S_REC) || last;
    exp_done = (m_state == S_DONE) && !last;
    @(posedge clk);
    #1;
    check("ram_wren", 64'(ram_wren), 64'(cap));
    if (ram_wren === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", 64'(1), 64'(0));
      end else begin
        w = sb_q.pop_front();
        check("ram_addr", 64'(ram_addr), 64'(w.addr));
        check("ram_data", 64'(ram_data), 64'(w.data));
      end
    end
    sb_q.delete();
    check("busy", 64'(busy), 64'(exp_busy));
    check("done", 64'(done), 64'(exp_done));
    check("count", 64'(count), 64'(m_count));
    check("peak", 64'(peak), 64'(m_peak));
    check("wrapped", 64'(wrapped), 64'(m_wrapped));
  endtask

  initial begin
    vecs[0] = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 23'h7FFFFF};
    vecs[1] = '{24'h800000, 24'h800000, 24'h800000, 23'h7FFFFF};
    vecs[2] = '{24'h000003, 24'hFFFFFC, 24'hFFFFFF, 23'h000001};
    vecs[3] = '{24'h000007, 24'h000000, 24'h000003, 23'h000003};
    vecs[4] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 23'h000001};
    vecs[5] = '{24'h000010, 24'h000020, 24'h000018, 23'h000018};
    vecs[6] = '{24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 23'h000100};

    model_reset();
    #12;
    check("reset_wren", 64'(ram_wren), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_addr", 64'(ram_addr), 64'(0));
    check("reset_data", 64'(ram_data), 64'(0));
    check("reset_count", 64'(count), 64'(0));
    check("reset_read", 64'(read), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // idle with traffic and stop: nothing happens
    step(0, 1, 0, 1, 24'h100, 24'h100);
    step(0, 0, 0, 1, 24'h100, 24'h100);

    // one-shot: start+stop together starts; 8 writes then done
    step(1, 1, 0, 1, 24'h1, 24'h1);
    for (int i = 0; i < 11; i++) step(0, 0, 0, 1, DW'($urandom), DW'($urandom));
    check("oneshot_count", 64'(count), 64'(DEPTH));
    check("oneshot_done", 64'(done), 64'(1));

    // mix vectors: stop, restart, single capture each
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 0, 0, '0, '0);
      step(1, 0, 0, 0, '0, '0);
      step(0, 0, 0, 1, vecs[i].l, vecs[i].r);
      check($sformatf("mix%0d_data", i), 64'(ram_data), 64'(vecs[i].exp_data));
      check($sformatf("mix%0d_peak", i), 64'(peak), 64'(vecs[i].exp_abs));
    end

    // loop mode: 20 captures with some idle gaps
    step(0, 1, 0, 0, '0, '0);
    step(1, 0, 1, 0, '0, '0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 1, DW'($urandom), DW'($urandom));
      if (i == 6) check("loop_not_wrapped", 64'(wrapped), 64'(0));
      if (i == 8) check("loop_wrapped", 64'(wrapped), 64'(1));
      if (i % 7 == 3) step(0, 0, 0, 0, '0, '0);
    end
    check("loop_count_sat", 64'(count), 64'(DEPTH));

    // start in REC ignored, then stop together with read_ready
    step(1, 0, 0, 1, 24'h400000, 24'h0);
    step(0, 1, 0, 1, 24'h7FFFFF, 24'h7FFFFF);
    check("stop_prev_write", 64'(ram_wren), 64'(0));
    step(0, 0, 0, 1, 24'h0, 24'h0);
    check("stop_done", 64'(done), 64'(1));

    // start in DONE restarts at address 0 with cleared count/peak
    step(1, 0, 0, 1, 24'h0, 24'h0);
    check("restart_count", 64'(count), 64'(0));
    check("restart_peak", 64'(peak), 64'(0));
    step(0, 0, 0, 1, 24'h000020, 24'h000020);
    check("restart_addr", 64'(ram_addr), 64'(0));

    // reset asserted mid-capture while ram_wren is high
    step(0, 0, 0, 1, 24'h000040, 24'h000040);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_wren", 64'(ram_wren), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_count", 64'(count), 64'(0));
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 0, 1, 24'h5, 24'h5);
    step(1, 0, 0, 1, 24'h5, 24'h5);
    step(0, 0, 0, 1, 24'h6, 24'h6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
